// File: rtl/uart_tx_word_feeder_if.sv
// Bundle of the word-feeder write side and its uart_tx byte-launch side.
//   master: producer/transmitter environment (drives wr_data, wr_valid, tx_busy)
//   slave : the feeder itself (drives wr_ready, fifo_count, tx_data, tx_start, idle)
interface uart_tx_word_feeder_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WORD_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [CNT_W-1:0]  fifo_count;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              idle;

    modport master (
        output wr_data, wr_valid, tx_busy,
        input  wr_ready, fifo_count, tx_data, tx_start, idle
    );

    modport slave (
        input  wr_data, wr_valid, tx_busy,
        output wr_ready, fifo_count, tx_data, tx_start, idle
    );
endinterface

// File: rtl/uart_tx_word_feeder.sv
// Buffers WORD_W-bit result words in a small FIFO and serializes each word,
// LSB byte first, onto the uart_tx byte interface, honouring its busy flag.
// Optional macro UART_FEEDER_CHECKSUM_EN appends one XOR checksum byte per word.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   bus (slave)     wr_data/wr_valid/wr_ready  word write handshake
//                   fifo_count                 stored words (registered)
//                   tx_data/tx_start/tx_busy   uart_tx byte launch handshake
//                   idle                       FIFO empty and FSM idle
module uart_tx_word_feeder #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_word_feeder_if.slave bus
);
    localparam int unsigned BYTES = WORD_W / 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
`ifdef UART_FEEDER_CHECKSUM_EN
    localparam int unsigned NBYTES = BYTES + 1;
`else
    localparam int unsigned NBYTES = BYTES;
`endif
    localparam int unsigned IDX_W = ($clog2(NBYTES) > 0) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ACK   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    state_t            state;
    logic [WORD_W-1:0] word_reg;
    logic [IDX_W-1:0]  byte_idx;
    logic              tx_start_q;
    logic [7:0]        tx_data_q;
    logic [7:0]        cur_byte;
    logic              push;
    logic              pop;

    // Pop only from S_IDLE on the registered count, so a word is never bypassed
    assign bus.wr_ready   = (count_q < CNT_W'(DEPTH));
    assign push           = bus.wr_valid && bus.wr_ready;
    assign pop            = (state == S_IDLE) && (count_q != '0);
    assign bus.fifo_count = count_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.idle       = (state == S_IDLE) && (count_q == '0);

`ifdef UART_FEEDER_CHECKSUM_EN
    logic [7:0] csum_reg;

    function automatic logic [7:0] word_xor(input logic [WORD_W-1:0] w);
        logic [7:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            acc = acc ^ w[8*i +: 8];
        end
        return acc;
    endfunction
`endif

    // Byte selected by byte_idx; the index past the data bytes is the checksum
    always_comb begin
        cur_byte = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (byte_idx == IDX_W'(i)) begin
                cur_byte = word_reg[8*i +: 8];
            end
        end
`ifdef UART_FEEDER_CHECKSUM_EN
        if (byte_idx == IDX_W'(BYTES)) begin
            cur_byte = csum_reg;
        end
`endif
    end

    // FIFO storage (data only, not reset)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Byte sequencer: pop word, then issue/ack/done per byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            word_reg   <= '0;
            byte_idx   <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
`ifdef UART_FEEDER_CHECKSUM_EN
            csum_reg   <= '0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        word_reg <= mem[rd_ptr];
                        byte_idx <= '0;
                        state    <= S_ISSUE;
`ifdef UART_FEEDER_CHECKSUM_EN
                        csum_reg <= word_xor(mem[rd_ptr]);
`endif
                    end
                end
                S_ISSUE: begin
                    if (!bus.tx_busy) begin
                        tx_data_q  <= cur_byte;
                        tx_start_q <= 1'b1;
                        state      <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (bus.tx_busy) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!bus.tx_busy) begin
                        if (byte_idx < IDX_W'(NBYTES - 1)) begin
                            byte_idx <= byte_idx + IDX_W'(1);
                            state    <= S_ISSUE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_word_feeder.sv
// Self-checking bench for uart_tx_word_feeder: uart_tx busy model, byte
// scoreboard fed from pushed words, directed scenarios plus random traffic.
module tb_uart_tx_word_feeder;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned BYTES    = WORD_W / 8;
    localparam int unsigned BUSY_LEN = 20;
`ifdef UART_FEEDER_CHECKSUM_EN
    localparam int unsigned NB = BYTES + 1;
`else
    localparam int unsigned NB = BYTES;
`endif

    logic       clk;
    logic       rst;
    bit         force_busy;
    int         busy_cnt;
    int         pulses;
    logic       prev_start;
    logic [7:0] exp_q[$];
    int         n_checks;
    int         n_errors;

    uart_tx_word_feeder_if #(.WORD_W(WORD_W), .DEPTH(DEPTH)) bus ();

    uart_tx_word_feeder #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected byte stream of one word: LSB first, optional XOR checksum
    task automatic push_expect(input logic [31:0] w);
        for (int i = 0; i < int'(BYTES); i++) begin
            exp_q.push_back(w[8*i +: 8]);
        end
`ifdef UART_FEEDER_CHECKSUM_EN
        exp_q.push_back(w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]);
`endif
    endtask

    // uart_tx model: busy is a register that rises the cycle after tx_start
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.tx_busy <= 1'b0;
            busy_cnt    <= 0;
        end else if (force_busy) begin
            bus.tx_busy <= 1'b1;
            busy_cnt    <= 0;
        end else if (busy_cnt != 0) begin
            busy_cnt    <= busy_cnt - 1;
            bus.tx_busy <= (busy_cnt != 1);
        end else if (bus.tx_start) begin
            bus.tx_busy <= 1'b1;
            busy_cnt    <= int'(BUSY_LEN);
        end else begin
            bus.tx_busy <= 1'b0;
        end
    end

    // Byte monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && bus.tx_start) begin
            pulses++;
            check("start_while_busy", 32'(bus.tx_busy), 32'd0);
            check("start_repeat", 32'(prev_start), 32'd0);
            if (exp_q.size() == 0) begin
                check("extra_byte", 32'(bus.tx_data), 32'hFFFF_FFFF);
            end else begin
                check("byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            end
        end
        prev_start = rst ? 1'b0 : bus.tx_start;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w, input bit exp_acc, input string tag);
        bus.wr_data  = w;
        bus.wr_valid = 1'b1;
        check({tag, "_ready"}, 32'(bus.wr_ready), 32'(exp_acc));
        step();
        bus.wr_valid = 1'b0;
        if (exp_acc) push_expect(w);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 6000; i++) begin
            if (exp_q.size() == 0 && !bus.tx_busy && bus.idle) break;
            step();
        end
        check({tag, "_idle"}, 32'(bus.idle), 32'd1);
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_pulses(input int target, input string tag);
        int n;
        n = 0;
        while (pulses < target && n < 3000) begin
            step();
            n++;
        end
        check({tag, "_pulses"}, 32'(pulses >= target), 32'd1);
    endtask

    initial begin
        int base;
        int n;
        n_checks     = 0;
        n_errors     = 0;
        pulses       = 0;
        prev_start   = 1'b0;
        force_busy   = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        rst          = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_count", 32'(bus.fifo_count), 32'd0);
        check("rst_idle", 32'(bus.idle), 32'd1);
        check("rst_ready", 32'(bus.wr_ready), 32'd1);
        step();
        step();
        rst = 1'b0;
        step();

        // Single word, latency and byte order
        base = pulses;
        push(32'hA1B2C3D4, 1'b1, "single");
        check("single_lat0", 32'(bus.tx_start), 32'd0);
        check("single_busy_idle", 32'(bus.idle), 32'd0);
        step();
        check("single_lat1", 32'(bus.tx_start), 32'd0);
        step();
        check("single_lat2", 32'(bus.tx_start), 32'd1);
        wait_done("single");
        check("single_nbytes", 32'(pulses - base), 32'(NB));

        // Full FIFO / overflow: blocker word stalls the FSM in issue
        force_busy = 1'b1;
        step();
        push(32'h0000_00B0, 1'b1, "blocker");
        step();
        step();
        check("blocker_popped", 32'(bus.fifo_count), 32'd0);
        for (int i = 1; i <= 9; i++) begin
            push(32'(i), (i <= int'(DEPTH)), "full_push");
        end
        check("full_count", 32'(bus.fifo_count), 32'(DEPTH));
        check("full_ready", 32'(bus.wr_ready), 32'd0);
        force_busy = 1'b0;
        wait_done("full");

        // Simultaneous push and pop with three words stored
        force_busy = 1'b1;
        step();
        base = pulses;
        push(32'h5566_7788, 1'b1, "sim_a");
        step();
        step();
        push(32'h1111_2222, 1'b1, "sim_b");
        push(32'h3333_4444, 1'b1, "sim_c");
        push(32'h5555_6666, 1'b1, "sim_d");
        check("sim_count_pre", 32'(bus.fifo_count), 32'd3);
        force_busy = 1'b0;
        wait_pulses(base + int'(NB), "sim_a");
        n = 0;
        while (!bus.tx_busy && n < 100) begin step(); n++; end
        while (bus.tx_busy && n < 200) begin step(); n++; end
        check("sim_count_fall", 32'(bus.fifo_count), 32'd3);
        step();
        push(32'hEEEE_0001, 1'b1, "sim_e");
        check("sim_count_post", 32'(bus.fifo_count), 32'd3);
        check("sim_not_idle", 32'(bus.idle), 32'd0);
        wait_done("simul");

        // Reset in the middle of a word with two words queued
        base = pulses;
        push(32'hA1B2C3D4, 1'b1, "rmw_a");
        push(32'h0BAD_0001, 1'b1, "rmw_b");
        push(32'h0BAD_0002, 1'b1, "rmw_c");
        wait_pulses(base + 2, "rmw_c3");
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("rmw_tx_start", 32'(bus.tx_start), 32'd0);
        check("rmw_count", 32'(bus.fifo_count), 32'd0);
        check("rmw_idle", 32'(bus.idle), 32'd1);
        step();
        step();
        rst = 1'b0;
        base = pulses;
        repeat (300) step();
        check("rmw_no_bytes", 32'(pulses - base), 32'd0);

        // Random traffic; outstanding words kept below DEPTH so all pushes land
        for (int k = 0; k < 25; k++) begin
            n = 0;
            while (((exp_q.size() + int'(NB) - 1) / int'(NB)) >= int'(DEPTH) && n < 3000) begin
                step();
                n++;
            end
            push($urandom, 1'b1, "rand");
            repeat ($urandom_range(0, 40)) step();
        end
        wait_done("rand");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_word_feeder.md
Name: uart_tx_word_feeder

Overview:
- Buffers WORD_W-bit result words from the accelerator datapath in a small FIFO.
- Serializes each word into bytes, LSB first, and drives the uart_tx byte interface (tx_data/tx_start) while honouring its registered busy flag.
- Sits directly upstream of the UART transmitter, between the result writeback and the serial link.

Parameters:
- WORD_W, 32, width of input words; must be a multiple of 8. BYTES = WORD_W/8.
- DEPTH, 8, FIFO depth in words; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- wr_data  in  WORD_W  word to enqueue
- wr_valid  in  1  write request; accepted when wr_valid && wr_ready
- wr_ready  out  1  FIFO not full; equals (fifo_count < DEPTH), combinational from registered count
- fifo_count  out  $clog2(DEPTH)+1  words currently stored, registered
- tx_data  out  8  byte presented to uart_tx
- tx_start  out  1  one-cycle launch pulse to uart_tx
- tx_busy  in  1  uart_tx busy; rises the cycle after tx_start, falls after the stop bit
- idle  out  1  high when FIFO is empty and FSM is in S_IDLE

Behaviour:
- Reset (async) values: fifo_count=0, wr_ptr=rd_ptr=0, state=S_IDLE, tx_start=0, tx_data=0, byte_idx=0, idle=1, wr_ready=1.
- FIFO
  - Push on wr_valid && wr_ready; the word is stored at wr_ptr, which wraps modulo DEPTH.
  - Pop occurs only in the S_IDLE to S_ISSUE transition.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - A word pushed in cycle N is poppable no earlier than N+1; there is no bypass.
  - Write while full: ignored. Data, count and pointers are unchanged.
- FSM states:
  - S_IDLE: if fifo_count != 0, pop the head into word_reg, byte_idx <= 0, go to S_ISSUE.
  - S_ISSUE: wait until tx_busy == 0. Then drive tx_data = word_reg[8*byte_idx +: 8], tx_start = 1 for exactly one cycle, go to S_ACK.
  - S_ACK: hold tx_data. Wait for tx_busy == 1, then go to S_DONE. tx_start must not be re-asserted here.
  - S_DONE: wait for tx_busy == 0.
    - If byte_idx < BYTES-1: byte_idx++, go to S_ISSUE.
    - Else go to S_IDLE.
  - Any illegal state goes to S_IDLE.
- Latency: word accepted in cycle N with the FSM idle and tx_busy low gives first tx_start in cycle N+2.
- Ordering: byte 0 = wr_data[7:0] is sent first. Words are sent strictly in FIFO order.
- tx_data keeps the last-sent byte when not transmitting.
- Simultaneous events:
  - wr_valid during a pop is legal.
  - tx_busy already high on entry to S_ISSUE stalls the FSM; no pulse is issued until busy drops.
- Reset mid-word: the current word and all queued words are discarded. tx_start drops immediately.

Optional Feature:
- Macro: UART_FEEDER_CHECKSUM_EN.
- Defined:
  - After the last data byte of each word, the FSM sends one extra byte equal to the XOR of all BYTES data bytes, using the same S_ISSUE/S_ACK/S_DONE sequence.
  - Effective bytes per word = BYTES+1.
  - The checksum is computed from word_reg at pop time and held in a register.
- Undefined: exactly BYTES bytes per word; no checksum logic is synthesized.

Test Plan:
- Single word: push 0xA1B2C3D4 with uart_tx model idle.
  - Required: 4 tx_start pulses with tx_data D4, C3, B2, A1.
  - Required: first pulse 2 cycles after the write; idle returns to 1 after the final busy fall.
- Busy handshake: tx_busy model rises 1 cycle after tx_start and stays high for 20 cycles.
  - Required: exactly one tx_start per byte.
  - Required: no pulse while tx_busy=1; next pulse only after busy falls.
- Full/overflow: hold tx_busy=1, push 9 words 0x1..0x9.
  - Required: after the first pop, fifo_count reaches 8 and wr_ready=0.
  - Required: the 9th word is dropped.
  - Required: after release, words are sent in order and 0x9 is never sent.
- Simultaneous push/pop: fifo_count=3 with the FSM popping while wr_valid=1 in the same cycle.
  - Required: fifo_count stays 3 and the pushed word is sent last.
- Reset mid-word: assert rst after byte C3 of 0xA1B2C3D4 with 2 more words queued.
  - Required: tx_start=0, fifo_count=0, idle=1.
  - Required: no further bytes after reset release.
- Checksum (UART_FEEDER_CHECKSUM_EN): push 0xA1B2C3D4.
  - Required: bytes D4, C3, B2, A1, 04.
  - Required: without the macro, only 4 bytes are sent.
